// File: rtl/gstmcu_pkg.sv
// Shared definitions for the GSTMCU sound-DMA block: register word indices,
// control bit positions, the address-generator state type and a byte-lane helper.
package gstmcu_pkg;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_START_HI = 4'd1;
    localparam logic [3:0] REG_START_MI = 4'd2;
    localparam logic [3:0] REG_START_LO = 4'd3;
    localparam logic [3:0] REG_CNT_HI   = 4'd4;
    localparam logic [3:0] REG_CNT_MI   = 4'd5;
    localparam logic [3:0] REG_CNT_LO   = 4'd6;
    localparam logic [3:0] REG_END_HI   = 4'd7;
    localparam logic [3:0] REG_END_MI   = 4'd8;
    localparam logic [3:0] REG_END_LO   = 4'd9;

    localparam int CTRL_SNDON = 0;
    localparam int CTRL_SFREP = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FEND = 2'd3
    } snd_state_t;

    // Pick one byte of a 24-bit byte address: lane 2 = hi, 1 = mid, 0 = lo.
    function automatic logic [7:0] lane_byte(input logic [23:0] addr, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd2:    b = addr[23:16];
            2'd1:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/snd_addr_reg.sv
// Three-lane (hi/mid/lo) CPU-writable word address register.
// Each lane is written independently; lo bit0 does not exist (word aligned).
module snd_addr_reg
    import gstmcu_pkg::*;
#(
    parameter int AW = 21
) (
    input  logic            clk32,
    input  logic            porb,
    input  logic            we_hi,
    input  logic            we_mid,
    input  logic            we_lo,
    input  logic [AW-16:0]  hi_din,
    input  logic [7:0]      mid_din,
    input  logic [7:1]      lo_din,
    output logic [AW:1]     addr
);

    // Byte-lane writes into the stored address.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            addr <= '0;
        end else begin
            if (we_hi)  addr[AW:16] <= hi_din;
            if (we_mid) addr[15:8]  <= mid_din;
            if (we_lo)  addr[7:1]   <= lo_din;
        end
    end

endmodule

// File: rtl/snd_dma_addr.sv
// STE sound-DMA address generator: control/start/end registers, the live
// sound address counter and the frame load/run/end/repeat sequencing.
module snd_dma_addr
    import gstmcu_pkg::*;
#(
    parameter int AW = 21
) (
    input  logic        clk32,
    input  logic        porb,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    input  logic        snd_adv,
    output logic [AW:1] snd,
    output logic [AW:1] sft,
    output logic        sndon,
    output logic        sfrep,
    output logic        frame_irq
);

    snd_state_t  state;
    snd_state_t  next_state;
    logic        wr;
    logic        rd;
    logic        wr_ctrl;
    logic        stop_req;
    logic        load_en;
    logic        inc_en;
    logic        clr_on;
    logic [AW:1] start_addr;
    logic [AW:1] end_addr;
    logic [23:0] start24;
    logic [23:0] end24;
    logic [23:0] snd24;

    assign wr       = bus_cs & bus_we;
    assign rd       = bus_cs & ~bus_we;
    assign wr_ctrl  = wr && (bus_addr == REG_CTRL);
    assign stop_req = wr_ctrl && !bus_din[CTRL_SNDON];

    snd_addr_reg #(.AW(AW)) u_start (
        .clk32   (clk32),
        .porb    (porb),
        .we_hi   (wr && (bus_addr == REG_START_HI)),
        .we_mid  (wr && (bus_addr == REG_START_MI)),
        .we_lo   (wr && (bus_addr == REG_START_LO)),
        .hi_din  (bus_din[AW-16:0]),
        .mid_din (bus_din),
        .lo_din  (bus_din[7:1]),
        .addr    (start_addr)
    );

    snd_addr_reg #(.AW(AW)) u_end (
        .clk32   (clk32),
        .porb    (porb),
        .we_hi   (wr && (bus_addr == REG_END_HI)),
        .we_mid  (wr && (bus_addr == REG_END_MI)),
        .we_lo   (wr && (bus_addr == REG_END_LO)),
        .hi_din  (bus_din[AW-16:0]),
        .mid_din (bus_din),
        .lo_din  (bus_din[7:1]),
        .addr    (end_addr)
    );

    // Frame sequencer state register.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state plus load/increment/stop strobes; a stop write always beats
    // both the frame-end compare and a repeat reload.
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        inc_en     = 1'b0;
        clr_on     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_ctrl && bus_din[CTRL_SNDON]) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                load_en    = 1'b1;
                next_state = stop_req ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop_req)        next_state = ST_IDLE;
                else if (snd == sft) next_state = ST_FEND;
                else if (snd_adv)    inc_en     = 1'b1;
            end
            ST_FEND: begin
                if (!stop_req && sfrep && sndon) begin
                    next_state = ST_LOAD;
                end else begin
                    next_state = ST_IDLE;
                    clr_on     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign frame_irq = (state == ST_FEND);

    // Live counter and latched frame end; increment wraps modulo 2^AW.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            snd <= '0;
            sft <= '0;
        end else if (load_en) begin
            snd <= start_addr;
            sft <= end_addr;
        end else if (inc_en) begin
            snd <= snd + 1'b1;
        end
    end

    // Control bits; a non-repeating frame end switches the DMA off.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            sndon <= 1'b0;
            sfrep <= 1'b0;
        end else begin
            if (wr_ctrl) sfrep <= bus_din[CTRL_SFREP];
            if (clr_on)       sndon <= 1'b0;
            else if (wr_ctrl) sndon <= bus_din[CTRL_SNDON];
        end
    end

    assign start24 = 24'({start_addr, 1'b0});
    assign end24   = 24'({end_addr, 1'b0});
    assign snd24   = 24'({snd, 1'b0});

    // Registered read port; holds its value between read strobes.
    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            bus_dout <= 8'h00;
        end else if (rd) begin
            case (bus_addr)
                REG_CTRL:     bus_dout <= {6'b0, sfrep, sndon};
                REG_START_HI: bus_dout <= lane_byte(start24, 2'd2);
                REG_START_MI: bus_dout <= lane_byte(start24, 2'd1);
                REG_START_LO: bus_dout <= lane_byte(start24, 2'd0);
                REG_CNT_HI:   bus_dout <= lane_byte(snd24, 2'd2);
                REG_CNT_MI:   bus_dout <= lane_byte(snd24, 2'd1);
                REG_CNT_LO:   bus_dout <= lane_byte(snd24, 2'd0);
                REG_END_HI:   bus_dout <= lane_byte(end24, 2'd2);
                REG_END_MI:   bus_dout <= lane_byte(end24, 2'd1);
                REG_END_LO:   bus_dout <= lane_byte(end24, 2'd0);
                default:      bus_dout <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_snd_dma_addr.sv
// Directed bench for snd_dma_addr: reset, single frame, repeat, stop, wrap,
// zero-length frame and asynchronous reset.
module tb_snd_dma_addr;

    logic        clk32 = 1'b0;
    logic        porb = 1'b0;
    logic        bus_cs = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'd0;
    logic [7:0]  bus_din = 8'd0;
    logic [7:0]  bus_dout;
    logic        snd_adv = 1'b0;
    logic [21:1] snd;
    logic [21:1] sft;
    logic        sndon;
    logic        sfrep;
    logic        frame_irq;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;
    int irq_mark = 0;
    logic [7:0] d;

    snd_dma_addr #(.AW(21)) dut (
        .clk32     (clk32),
        .porb      (porb),
        .bus_cs    (bus_cs),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .snd_adv   (snd_adv),
        .snd       (snd),
        .sft       (sft),
        .sndon     (sndon),
        .sfrep     (sfrep),
        .frame_irq (frame_irq)
    );

    always #5 clk32 = ~clk32;

    always @(posedge clk32) if (frame_irq) irq_cnt <= irq_cnt + 1;

    function automatic logic [31:0] bytea(input logic [21:1] a);
        return {10'b0, a, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_din = v;
        tick();
        bus_cs = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
        tick();
        bus_cs = 1'b0;
        v = bus_dout;
    endtask

    task automatic adv_n(input int n);
        snd_adv = 1'b1;
        for (int k = 0; k < n; k++) tick();
        snd_adv = 1'b0;
    endtask

    initial begin
        // ---- reset ----
        tick(); tick();
        check("rst_snd", bytea(snd), 32'h0);
        check("rst_sft", bytea(sft), 32'h0);
        check("rst_sndon", 32'(sndon), 32'd0);
        check("rst_sfrep", 32'(sfrep), 32'd0);
        check("rst_irq", 32'(frame_irq), 32'd0);
        check("rst_dout", 32'(bus_dout), 32'h0);
        #2 porb = 1'b1;
        tick();
        check("rst_state", 32'(dut.state), 32'(gstmcu_pkg::ST_IDLE));
        for (int i = 0; i < 10; i++) begin
            rd(4'(i), d);
            check($sformatf("rst_reg%0d", i), 32'(d), 32'h0);
        end

        // ---- single frame 0x010000..0x010008 ----
        wr(4'd1, 8'h01); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
        wr(4'd7, 8'h01); wr(4'd8, 8'h00); wr(4'd9, 8'h08);
        irq_mark = irq_cnt;
        wr(4'd0, 8'h01);
        check("sf_sndon_load", 32'(sndon), 32'd1);
        check("sf_snd_preload", bytea(snd), 32'h0);
        tick();
        check("sf_snd_loaded", bytea(snd), 32'h010000);
        check("sf_sft_loaded", bytea(sft), 32'h010008);
        adv_n(4);
        check("sf_snd_end", bytea(snd), 32'h010008);
        check("sf_irq_before", 32'(frame_irq), 32'd0);
        tick();
        check("sf_irq_fend", 32'(frame_irq), 32'd1);
        tick();
        check("sf_irq_after", 32'(frame_irq), 32'd0);
        check("sf_sndon_off", 32'(sndon), 32'd0);
        check("sf_irq_count", 32'(irq_cnt - irq_mark), 32'd1);
        rd(4'd4, d); check("sf_cnt_hi", 32'(d), 32'h01);
        rd(4'd5, d); check("sf_cnt_mi", 32'(d), 32'h00);
        rd(4'd6, d); check("sf_cnt_lo", 32'(d), 32'h08);
        tick(); tick();
        check("sf_dout_hold", 32'(bus_dout), 32'h08);
        rd(4'd0, d); check("sf_ctrl", 32'(d), 32'h00);

        // ---- repeat, end moved to 0x010004 during frame 1 ----
        irq_mark = irq_cnt;
        wr(4'd0, 8'h03);
        tick();
        check("rp_snd_f1", bytea(snd), 32'h010000);
        wr(4'd9, 8'h04);
        check("rp_sft_kept", bytea(sft), 32'h010008);
        adv_n(4);
        check("rp_snd_f1_end", bytea(snd), 32'h010008);
        tick();
        check("rp_irq_f1", 32'(frame_irq), 32'd1);
        tick();
        check("rp_sndon_load", 32'(sndon), 32'd1);
        tick();
        check("rp_snd_f2", bytea(snd), 32'h010000);
        check("rp_sft_f2", bytea(sft), 32'h010004);
        adv_n(2);
        check("rp_snd_f2_end", bytea(snd), 32'h010004);
        tick();
        check("rp_irq_f2", 32'(frame_irq), 32'd1);
        tick(); tick();
        check("rp_snd_reload", bytea(snd), 32'h010000);
        wr(4'd0, 8'h00);
        check("rp_stop_state", 32'(dut.state), 32'(gstmcu_pkg::ST_IDLE));
        check("rp_irq_count", 32'(irq_cnt - irq_mark), 32'd2);

        // ---- mid-frame stop ----
        wr(4'd9, 8'h08);
        irq_mark = irq_cnt;
        wr(4'd0, 8'h01);
        tick();
        adv_n(1);
        check("st_snd_run", bytea(snd), 32'h010002);
        wr(4'd0, 8'h00);
        check("st_state", 32'(dut.state), 32'(gstmcu_pkg::ST_IDLE));
        check("st_snd_hold", bytea(snd), 32'h010002);
        check("st_sndon", 32'(sndon), 32'd0);
        adv_n(3);
        tick();
        check("st_adv_ignored", bytea(snd), 32'h010002);
        check("st_no_irq", 32'(irq_cnt - irq_mark), 32'd0);

        // ---- wrap: 0x3FFFFE -> 0x000000 -> 0x000002 ----
        wr(4'd1, 8'h3F); wr(4'd2, 8'hFF); wr(4'd3, 8'hFE);
        wr(4'd7, 8'h00); wr(4'd8, 8'h00); wr(4'd9, 8'h02);
        rd(4'd3, d); check("wr_start_lo", 32'(d), 32'hFE);
        wr(4'd0, 8'h01);
        tick();
        check("wr_snd_start", bytea(snd), 32'h3FFFFE);
        adv_n(1);
        check("wr_snd_wrap", bytea(snd), 32'h000000);
        adv_n(1);
        check("wr_snd_end", bytea(snd), 32'h000002);
        tick();
        check("wr_irq", 32'(frame_irq), 32'd1);
        tick();

        // ---- zero-length frame ----
        wr(4'd7, 8'h3F); wr(4'd8, 8'hFF); wr(4'd9, 8'hFE);
        irq_mark = irq_cnt;
        wr(4'd0, 8'h01);
        check("zl_irq_load", 32'(frame_irq), 32'd0);
        tick();
        check("zl_irq_run", 32'(frame_irq), 32'd0);
        tick();
        check("zl_irq_fend", 32'(frame_irq), 32'd1);
        check("zl_snd", bytea(snd), 32'h3FFFFE);
        tick();
        check("zl_irq_count", 32'(irq_cnt - irq_mark), 32'd1);

        // ---- asynchronous reset mid-frame ----
        wr(4'd1, 8'h01); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
        wr(4'd7, 8'h01); wr(4'd8, 8'h00); wr(4'd9, 8'h08);
        wr(4'd0, 8'h01);
        tick();
        adv_n(1);
        snd_adv = 1'b1;
        check("ar_snd_pre", bytea(snd), 32'h010002);
        #1 porb = 1'b0;
        #1;
        check("ar_snd", bytea(snd), 32'h0);
        check("ar_sft", bytea(sft), 32'h0);
        check("ar_sndon", 32'(sndon), 32'd0);
        check("ar_irq", 32'(frame_irq), 32'd0);
        #1 porb = 1'b1;
        snd_adv = 1'b0;
        tick();
        rd(4'd0, d); check("ar_ctrl", 32'(d), 32'h00);
        rd(4'd1, d); check("ar_start_hi", 32'(d), 32'h00);
        wr(4'd1, 8'hFF);
        rd(4'd1, d); check("hi_mask", 32'(d), 32'h3F);
        wr(4'd4, 8'hFF);
        rd(4'd4, d); check("cnt_ro", 32'(d), 32'h00);
        wr(4'd12, 8'hFF);
        rd(4'd12, d); check("unmapped", 32'(d), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
